// File: rtl/pmp_pkg.sv
// Shared encodings for the PMP match engine: cfg field positions, address-match
// modes, privilege and access-type codes, and the scan FSM states.
package pmp_pkg;

  // Bit positions inside one 8-bit pmpcfg entry.
  localparam int CFG_R    = 0;
  localparam int CFG_W    = 1;
  localparam int CFG_X    = 2;
  localparam int CFG_A_LO = 3;
  localparam int CFG_A_HI = 4;
  localparam int CFG_L    = 7;

  // Address-matching mode held in the A field.
  typedef enum logic [1:0] {
    A_OFF   = 2'd0,
    A_TOR   = 2'd1,
    A_NA4   = 2'd2,
    A_NAPOT = 2'd3
  } pmp_a_e;

  // Privilege level of the requester; code 2 is unused.
  typedef enum logic [1:0] {
    PRIV_U = 2'd0,
    PRIV_S = 2'd1,
    PRIV_M = 2'd3
  } pmp_priv_e;

  // Access type; the reserved code is checked like an execute.
  typedef enum logic [1:0] {
    ACC_R    = 2'd0,
    ACC_W    = 2'd1,
    ACC_X    = 2'd2,
    ACC_RSVD = 2'd3
  } pmp_acc_e;

  // Scan FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_RESP = 2'd2
  } pmp_state_e;

endpackage

// File: rtl/pmp_entry_match.sv
// Range decode for a single PMP entry. Classifies an access [base, base+2^size-1]
// as a full or partial match against the entry's byte range. All address math is
// one bit wider than the physical address so a top-of-space bound never wraps.
module pmp_entry_match
  import pmp_pkg::*;
#(
  parameter int PA_WIDTH = 34
) (
  input  logic [7:0]          i_cfg,
  input  logic [PA_WIDTH-3:0] i_pmpaddr,
  input  logic [PA_WIDTH-3:0] i_prev,
  input  logic [PA_WIDTH-1:0] i_acc_base,
  input  logic [1:0]          i_acc_size,
  output logic                o_full,
  output logic                o_partial
);

  localparam int AW = PA_WIDTH + 1;
  localparam int PW = PA_WIDTH - 2;

  logic [AW-1:0] addr_b;
  logic [AW-1:0] prev_b;
  logic [AW-1:0] acc_lo;
  logic [AW-1:0] acc_hi;
  logic [AW-1:0] rng_lo;
  logic [AW-1:0] rng_hi;
  logic [AW-1:0] napot_mask;
  logic [PW:0]   addr_ext;
  logic [PW:0]   napot_ones;
  logic          rng_valid;
  logic          overlap;
  logic          unused_cfg_bits;

  // Permission and lock bits are evaluated by the caller, not here.
  assign unused_cfg_bits = ^{i_cfg[CFG_L:5], i_cfg[CFG_X:CFG_R]};

  assign addr_b = {1'b0, i_pmpaddr, 2'b00};
  assign prev_b = {1'b0, i_prev, 2'b00};
  assign acc_lo = {1'b0, i_acc_base};
  assign acc_hi = acc_lo + ((AW'(1) << i_acc_size) - AW'(1));

  // x ^ (x+1) sets bits 0..t where t is the trailing-ones count. The extra MSB
  // lets an all-ones pmpaddr yield an all-ones mask covering the whole space.
  assign addr_ext   = {1'b0, i_pmpaddr};
  assign napot_ones = addr_ext ^ (addr_ext + (PW + 1)'(1));
  assign napot_mask = {napot_ones, 2'b11};

  // Inclusive byte range [rng_lo, rng_hi] selected by the A field.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
    rng_valid = 1'b0;
    rng_lo    = '0;
    rng_hi    = '0;
    unique case (pmp_a_e'(i_cfg[CFG_A_HI:CFG_A_LO]))
      A_OFF: begin
        rng_valid = 1'b0;
      end
      A_TOR: begin
        rng_valid = (i_prev < i_pmpaddr);
        rng_lo    = prev_b;
        rng_hi    = addr_b - AW'(1);
      end
      A_NA4: begin
        rng_valid = 1'b1;
        rng_lo    = addr_b;
        rng_hi    = addr_b | AW'(3);
      end
      A_NAPOT: begin
        rng_valid = 1'b1;
        rng_lo    = addr_b & ~napot_mask;
        rng_hi    = addr_b | napot_mask;
      end
      default: rng_valid = 1'b0;
    endcase
  end

  assign overlap   = rng_valid && (acc_lo <= rng_hi) && (acc_hi >= rng_lo);
  assign o_full    = rng_valid && (acc_lo >= rng_lo) && (acc_hi <= rng_hi);
  assign o_partial = overlap && !o_full;

endmodule

// File: rtl/pmp_match_engine.sv
// Sequential PMP checker: accepts one physical-address request, walks the PMP
// entries in priority order one per cycle, and holds a hit/fault verdict on a
// valid/ready response port until the consumer takes it.
module pmp_match_engine
  import pmp_pkg::*;
#(
  parameter  int NUM_ENTRIES = 16,
  parameter  int PA_WIDTH    = 34,
  localparam int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_req_valid,
  output logic                            o_req_ready,
  input  logic [PA_WIDTH-1:0]             i_req_paddr,
  input  logic [1:0]                      i_req_size,
  input  logic [1:0]                      i_req_type,
  input  logic [1:0]                      i_req_priv,
  input  logic [8*NUM_ENTRIES-1:0]        i_pmpcfg,
  input  logic [(PA_WIDTH-2)*NUM_ENTRIES-1:0] i_pmpaddr,
  output logic                            o_rsp_valid,
  input  logic                            i_rsp_ready,
  output logic                            o_rsp_hit,
  output logic                            o_rsp_fault,
  output logic [IDX_W-1:0]                o_rsp_idx,
  output logic                            o_busy
);

  localparam int PW = PA_WIDTH - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENTRIES - 1);

  pmp_state_e          state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PW-1:0]       prev_q, prev_d;
  logic [PA_WIDTH-1:0] paddr_q, paddr_d;
  logic [1:0]          size_q, size_d;
  logic [1:0]          type_q, type_d;
  logic [1:0]          priv_q, priv_d;
  logic                hit_q, hit_d;
  logic                fault_q, fault_d;
  logic [IDX_W-1:0]    rsp_idx_q, rsp_idx_d;

  logic [7:0]          cfg_arr  [NUM_ENTRIES];
  logic [PW-1:0]       addr_arr [NUM_ENTRIES];
  logic [7:0]          cfg_sel;
  logic [PW-1:0]       addr_sel;
  logic                ent_full;
  logic                ent_partial;
  logic                perm_bit;
  logic                allowed;

  // Unpack the flat configuration buses into per-entry views.
  always_comb begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      cfg_arr[i]  = i_pmpcfg[8*i +: 8];
      addr_arr[i] = i_pmpaddr[PW*i +: PW];
    end
  end

  assign cfg_sel  = cfg_arr[idx_q];
  assign addr_sel = addr_arr[idx_q];

  pmp_entry_match #(
    .PA_WIDTH (PA_WIDTH)
  ) u_entry_match (
    .i_cfg      (cfg_sel),
    .i_pmpaddr  (addr_sel),
    .i_prev     (prev_q),
    .i_acc_base (paddr_q),
    .i_acc_size (size_q),
    .o_full     (ent_full),
    .o_partial  (ent_partial)
  );

  // Permission bit for the latched access type; reserved type checks X.
  always_comb begin
    perm_bit = cfg_sel[CFG_X];
    unique case (pmp_acc_e'(type_q))
      ACC_R:   perm_bit = cfg_sel[CFG_R];
      ACC_W:   perm_bit = cfg_sel[CFG_W];
      default: perm_bit = cfg_sel[CFG_X];
    endcase
  end

  // Machine mode bypasses R/W/X unless the entry is locked.
  assign allowed = perm_bit || ((priv_q == PRIV_M) && !cfg_sel[CFG_L]);

  // Next-state logic: accept, scan one entry per cycle, then hold the verdict.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    prev_d    = prev_q;
    paddr_d   = paddr_q;
    size_d    = size_q;
    type_d    = type_q;
    priv_d    = priv_q;
    hit_d     = hit_q;
    fault_d   = fault_q;
    rsp_idx_d = rsp_idx_q;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          paddr_d = i_req_paddr & ~((PA_WIDTH'(1) << i_req_size) - PA_WIDTH'(1));
          size_d  = i_req_size;
          type_d  = i_req_type;
          priv_d  = i_req_priv;
          idx_d   = '0;
          prev_d  = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (ent_full || ent_partial) begin
          hit_d     = 1'b1;
          fault_d   = ent_partial || !allowed;
          rsp_idx_d = idx_q;
          state_d   = ST_RESP;
        end else if (idx_q == LAST_IDX) begin
          hit_d     = 1'b0;
          fault_d   = (priv_q != PRIV_M);
          rsp_idx_d = '0;
          state_d   = ST_RESP;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          prev_d = addr_sel;
        end
      end
      ST_RESP: begin
        if (i_rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response registers; reset abandons any in-flight request.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (rst) begin
      state_q   <= ST_IDLE;
      hit_q     <= 1'b0;
      fault_q   <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      hit_q     <= hit_d;
      fault_q   <= fault_d;
      rsp_idx_q <= rsp_idx_d;
    end
  end

  // Request latches and scan pointers, reloaded on every accept.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath registers are left unreset; they are always written before being used.
    idx_q   <= idx_d;
    prev_q  <= prev_d;
    paddr_q <= paddr_d;
    size_q  <= size_d;
    type_q  <= type_d;
    priv_q  <= priv_d;
  end

  assign o_req_ready = (state_q == ST_IDLE);
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_busy      = (state_q != ST_IDLE);
  assign o_rsp_hit   = hit_q;
  assign o_rsp_fault = fault_q;
  assign o_rsp_idx   = rsp_idx_q;

endmodule

// File: doc/pmp_match_engine.md
# pmp_match_engine

Clocked PMP check engine downstream of the PMP-match click FIFO stage. Each fire of that stage hands this block one physical-address request. The block scans the PMP entries in priority order, one entry per cycle, and returns a single hit/fault verdict to the MMU response path over a valid/ready handshake.

## Interface
- NUM_ENTRIES, default 16: number of implemented PMP entries, 1..64.
- PA_WIDTH, default 34: physical address width; each pmpaddr is PA_WIDTH-2 bits.
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_req_valid  in  1  request present.
- o_req_ready  out  1  high only in IDLE.
- i_req_paddr  in  PA_WIDTH  byte address, naturally aligned to 2^size.
- i_req_size  in  2  access is 2^size bytes (1..8).
- i_req_type  in  2  0=R, 1=W, 2=X; 3 is reserved and treated as X.
- i_req_priv  in  2  0=U, 1=S, 3=M.
- i_pmpcfg  in  8*NUM_ENTRIES  entry i in bits [8i+7:8i]: L=7, A=4:3, X=2, W=1, R=0.
- i_pmpaddr  in  (PA_WIDTH-2)*NUM_ENTRIES  entry i holds PA[PA_WIDTH-1:2].
- o_rsp_valid  out  1  verdict present.
- i_rsp_ready  in  1  consumer accepts the verdict.
- o_rsp_hit  out  1  some entry matched, fully or partially.
- o_rsp_fault  out  1  access denied.
- o_rsp_idx  out  clog2(NUM_ENTRIES)  index of the matching entry; 0 when there is no hit.
- o_busy  out  1  high in SCAN or RESP; the CSR unit stalls pmpcfg/pmpaddr writes while it is high.

## Operation
- FSM states are IDLE, SCAN and RESP.
- IDLE -> SCAN on i_req_valid & o_req_ready:
  - latch paddr with its low size bits forced to 0, plus size, type and priv;
  - clear the scan index to 0 and the TOR lower bound to 0.
- SCAN: evaluate entry[idx] against the live cfg/addr buses. Range decode by A:
  - OFF: never matches.
  - TOR: entry range is [prev<<2, pmpaddr<<2). When prev >= pmpaddr it never matches. prev is 0 for entry 0.
  - NA4: 4 bytes at pmpaddr<<2.
  - NAPOT: with t = trailing ones of pmpaddr, size is 2^(t+3) bytes and the base is pmpaddr with its low t+1 bits cleared, shifted left by 2. All-ones pmpaddr covers the whole space.
- Match classification:
  - full: every byte of the access lies inside the range;
  - partial: some bytes lie inside, but not all;
  - none: no byte lies inside.
- Full match, permission check:
  - The access is allowed iff the R/W/X bit for the access type is 1.
  - Exception: when priv=M and L=0, the access is allowed regardless of R/W/X.
  - fault = not allowed.
- Partial match: fault=1, for every privilege level.
- On full or partial match: hit=1, idx=current index, go to RESP.
- On no match:
  - before the last entry: idx+1, prev = pmpaddr[idx], stay in SCAN;
  - at NUM_ENTRIES-1: hit=0, fault = (priv != M), go to RESP.
- Lowest-index match wins; later entries are never examined.
- RESP: hold o_rsp_valid and all rsp fields stable until i_rsp_ready, then go to IDLE.
- o_req_ready is low in SCAN and RESP; a request cannot be accepted in the cycle the response is consumed.

## Timing
- Reset values: state=IDLE, o_req_ready=1, o_rsp_valid=0, o_rsp_hit=0, o_rsp_fault=0, o_rsp_idx=0, o_busy=0.
- Accept in cycle t; entry i is evaluated in cycle t+1+i.
- o_rsp_valid rises in cycle t+2+k, where k is the matching index, or NUM_ENTRIES-1 when nothing matches.
- Minimum latency is 2 cycles. Maximum is NUM_ENTRIES+1.
- Earliest next accept is the cycle after the response handshake.
- Config buses must be stable from accept to response; o_busy guarantees this.
- rst asserted in any state: IDLE on the next edge. o_rsp_valid drops and the in-flight request is dropped with no response.
- Address arithmetic uses PA_WIDTH+1 bits so the upper bound never wraps. The access end address is paddr + 2^size - 1.

## Structure
- Package pmp_pkg holds:
  - cfg bit positions;
  - A encodings OFF=0, TOR=1, NA4=2, NAPOT=3;
  - priv encodings and access-type encodings;
  - the FSM state enum.
- Sub-module pmp_entry_match, combinational, one instance muxed by idx:
  - inputs: cfg, pmpaddr, prev, access base and size;
  - outputs: full and partial.
- The top level holds the FSM, request latches, idx/prev registers and response registers.

## Test plan
- Reset: assert rst for 2 cycles mid-SCAN -> next cycle o_req_ready=1, o_rsp_valid=0, o_busy=0, and no response is ever emitted.
- NAPOT hit:
  - setup: entry0 pmpaddr=0x2000_01FF, cfg=0x1B (4 KiB at 0x8000_0000, RW);
  - U read of 0x8000_0FFC, size 2, accepted at t -> o_rsp_valid at t+2, hit=1, fault=0, idx=0;
  - same setup, U execute -> fault=1, hit=1, idx=0.
- TOR at entry 2:
  - setup: entry0 OFF; entry1 OFF with pmpaddr=0x2000_0000; entry2 pmpaddr=0x2000_4000, cfg=0x09 (TOR, R);
  - S read of 0x8000_8000, size 3 -> valid at t+4, hit=1, fault=0, idx=2;
  - S write to the same address -> fault=1.
- Partial match:
  - setup: entries 0-2 OFF; entry3 pmpaddr=0x2400_0000, cfg=0x17 (NA4, RWX);
  - U read of 0x9000_0000, size 3 -> hit=1, fault=1, idx=3.
- No match, locked entry, backpressure:
  - setup: all entries OFF, NUM_ENTRIES=16;
  - M read -> valid at t+17, hit=0, fault=0;
  - U read -> fault=1;
  - entry0 cfg=0x99 (L, NAPOT, R), M write inside its range -> fault=1, idx=0;
  - hold i_rsp_ready=0 for 5 cycles -> rsp fields stable, o_req_ready=0, o_busy=1.
